// File: rtl/ser64_scan_ctrl.sv
// Serialises a 16x4 register file (64 bits) one bit at a time with ready/valid handshake.
// Optional trailing even-parity bit when SER64_PARITY_EN is defined.
module ser64_scan_ctrl #(
  parameter int unsigned BIT_DIV = 2
) (
  input  logic       tick,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] data_in,
  input  logic       sdo_ready,
  output logic [3:0] rg_a,
  output logic [1:0] bit_a,
  output logic       sdo,
  output logic       sdo_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] PRESC_LOAD = 4'(BIT_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
`ifdef SER64_PARITY_EN
    S_PAR,
`endif
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] presc_q, presc_d;
  logic       sdo_q, sdo_d;
  logic       vld_q, vld_d;
`ifdef SER64_PARITY_EN
  logic       parity_q, parity_d;
`endif

  always_ff @(posedge tick or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      presc_q  <= '0;
      sdo_q    <= 1'b0;
      vld_q    <= 1'b0;
`ifdef SER64_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      sdo_q    <= sdo_d;
      vld_q    <= vld_d;
`ifdef SER64_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    sdo_d    = sdo_q;
    vld_d    = vld_q;
`ifdef SER64_PARITY_EN
    parity_d = parity_q;
`endif
    // abort outranks every other input once a scan is running
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_FETCH;
            idx_d    = '0;
            presc_d  = PRESC_LOAD;
`ifdef SER64_PARITY_EN
            parity_d = 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (presc_q == 4'd0) begin
            sdo_d    = data_in[idx_q[1:0]];
            vld_d    = 1'b1;
            state_d  = S_SEND;
`ifdef SER64_PARITY_EN
            parity_d = parity_q ^ data_in[idx_q[1:0]];
`endif
          end else begin
            presc_d = presc_q - 4'd1;
          end
        end
        S_SEND: begin
          if (sdo_ready) begin
            if (idx_q != '1) begin
              idx_d   = idx_q + 6'd1;
              vld_d   = 1'b0;
              presc_d = PRESC_LOAD;
              state_d = S_FETCH;
            end else begin
`ifdef SER64_PARITY_EN
              // parity_q already includes bit 63, folded in during its FETCH
              sdo_d   = parity_q;
              state_d = S_PAR;
`else
              vld_d   = 1'b0;
              state_d = S_DONE;
`endif
            end
          end
        end
`ifdef SER64_PARITY_EN
        S_PAR: begin
          if (sdo_ready) begin
            vld_d   = 1'b0;
            state_d = S_DONE;
          end
        end
`endif
        S_DONE: begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  assign rg_a      = idx_q[5:2];
  assign bit_a     = idx_q[1:0];
  assign sdo       = sdo_q;
  assign sdo_valid = vld_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ser64_scan_ctrl.sv
// Self-checking bench for ser64_scan_ctrl: table-driven scans, hand sequences, randomized scans.
module tb_ser64_scan_ctrl;

  localparam int BD = 2;
`ifdef SER64_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FULL = 64 * (BD + 1) + PB;

  logic       tick = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sdo_ready = 1'b0;
  logic [3:0] data_in;
  logic [3:0] rg_a;
  logic [1:0] bit_a;
  logic       sdo, sdo_valid, busy, done;
  logic [3:0] mem [16];

  int checks = 0;
  int failures = 0;

  assign data_in = mem[rg_a];

  ser64_scan_ctrl #(.BIT_DIV(BD)) dut (
    .tick(tick), .clr(clr), .start(start), .abort(abort),
    .data_in(data_in), .sdo_ready(sdo_ready),
    .rg_a(rg_a), .bit_a(bit_a), .sdo(sdo), .sdo_valid(sdo_valid),
    .busy(busy), .done(done)
  );

  always #5 tick = ~tick;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge tick);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_vld"}, sdo_valid, 0);
    chk({tag, "_rga"}, rg_a, 0);
    chk({tag, "_bita"}, bit_a, 0);
  endtask

  // One scan checked against the expected bit stream and handshake timing.
  task automatic scan(input logic [3:0] fill, input logic [3:0] nib0, input bit rand_mem,
                      input int ready_pct, input int hold_bit, input int hold_len,
                      input int abort_bit, input int exp_done, input int exp_par,
                      input bit noisy);
    logic bits [65];
    logic par;
    int nb, e, h, pos;
    bit acc, rdy;
    for (int i = 0; i < 16; i++) mem[i] = rand_mem ? 4'($urandom) : fill;
    if (!rand_mem) mem[0] = nib0;
    par = 1'b0;
    for (int k = 0; k < 64; k++) begin
      bits[k] = mem[k / 4][k % 4];
      par ^= bits[k];
    end
    bits[64] = par;
    nb = 64 + PB;
    start = 1'b1; abort = 1'b0; sdo_ready = 1'b0;
    step();
    start = 1'b0;
    e = 0;
    for (int k = 0; k < nb; k++) begin
      pos = (k > 63) ? 63 : k;
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("rga", rg_a, pos / 4);
      chk("bita", bit_a, pos % 4);
      if (k < 64) begin
        chk("vld_launch", sdo_valid, 0);
        for (int c = 1; c <= BD; c++) begin
          if (noisy) start = 1'($urandom);
          sdo_ready = 1'($urandom);
          step(); e++;
          if (c < BD) chk("vld_fetch", sdo_valid, 0);
        end
      end
      chk("vld_bit", sdo_valid, 1);
      chk("sdo_bit", sdo, bits[k]);
      if (k == 64 && exp_par >= 0) chk("sdo_parity", sdo, exp_par);
      if (k == abort_bit) begin
        abort = 1'b1; sdo_ready = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; sdo_ready = 1'b0; start = 1'b0;
        chk_idle("abort");
        step();
        chk_idle("abort_post");
        return;
      end
      h = 0; acc = 1'b0;
      while (!acc) begin
        if (k == hold_bit && h < hold_len) rdy = 1'b0;
        else if (h >= 8) rdy = 1'b1;
        else rdy = (($urandom % 100) < ready_pct);
        sdo_ready = rdy;
        start = noisy ? 1'($urandom) : 1'b0;
        step(); e++; h++;
        if (rdy) acc = 1'b1;
        else begin
          chk("vld_hold", sdo_valid, 1);
          chk("sdo_hold", sdo, bits[k]);
          chk("rga_hold", rg_a, pos / 4);
          chk("bita_hold", bit_a, pos % 4);
          chk("done_hold", done, 0);
        end
      end
      sdo_ready = 1'b0; start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_vld", sdo_valid, 0);
    chk("done_busy", busy, 1);
    if (exp_done >= 0) chk("done_edge", e, exp_done);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_idle("after_done");
    step();
    chk_idle("after_done2");
  endtask

  typedef struct {
    logic [3:0] fill;
    logic [3:0] nib0;
    int ready_pct;
    int hold_bit;
    int hold_len;
    int abort_bit;
    int exp_done;
    int exp_par;
    bit noisy;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{4'hA, 4'hA, 100, -1, 0, -1, FULL,     0, 1'b0};
    tbl[1] = '{4'h0, 4'h1, 100, -1, 0, -1, FULL,     1, 1'b0};
    tbl[2] = '{4'hF, 4'hF, 100, -1, 0, -1, FULL,     0, 1'b1};
    tbl[3] = '{4'h5, 4'hA, 100,  7, 5, -1, FULL + 5, 0, 1'b0};
    tbl[4] = '{4'h3, 4'h7,  60, -1, 0, 20, -1,      -1, 1'b1};
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;

    repeat (3) @(posedge tick);
    #1;
    chk_idle("reset");
    chk("reset_sdo", sdo, 0);
    #4 clr = 1'b0;
    step();
    chk_idle("post_reset");
    step();
    chk_idle("post_reset2");

    for (int t = 0; t < 5; t++)
      scan(tbl[t].fill, tbl[t].nib0, 1'b0, tbl[t].ready_pct, tbl[t].hold_bit,
           tbl[t].hold_len, tbl[t].abort_bit, tbl[t].exp_done, tbl[t].exp_par, tbl[t].noisy);

    // asynchronous clear while fetching bit 9
    for (int i = 0; i < 16; i++) mem[i] = 4'hF;
    start = 1'b1;
    step();
    start = 1'b0; sdo_ready = 1'b1;
    repeat (9 * (BD + 1) + 1) step();
    chk("pre_clr_rga", rg_a, 2);
    chk("pre_clr_bita", bit_a, 1);
    chk("pre_clr_sdo", sdo, 1);
    chk("pre_clr_busy", busy, 1);
    #2 clr = 1'b1;
    #1;
    chk_idle("clr_async");
    chk("clr_sdo", sdo, 0);
    #2 clr = 1'b0;
    sdo_ready = 1'b0;
    step();
    chk_idle("after_clr");
    step();
    chk_idle("after_clr2");

    for (int r = 0; r < 8; r++) begin
      int ab;
      ab = (($urandom % 3) == 0) ? int'($urandom % (64 + PB)) : -1;
      scan(4'h0, 4'h0, 1'b1, 30 + int'($urandom % 71), -1, 0, ab, -1, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
